// File: rtl/sel_gen_pkg.sv
// Shared types and widths for the sel_gen grant arbiter.
package sel_gen_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/sel_gen_rr_pick.sv
// Combinational round-robin selector: first active request after last_grant wins.
module rr_pick
  import sel_gen_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] winner_c,
  output logic             any_c
);

  logic [SEL_W-1:0] idx;

  // Scan from farthest to nearest so the closest requester after last_grant wins.
  always_comb begin
    winner_c = last_grant;
    any_c    = |req;
    idx      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = last_grant + SEL_W'(i);
      if (req[idx]) winner_c = idx;
    end
  end

endmodule

// File: rtl/sel_gen.sv
// Round-robin single-grant select generator with hold timeout and a guaranteed gap cycle.
// Optional SEL_GEN_XCHK_EN: X/Z on req in IDLE pulses err instead of granting.
module sel_gen
  import sel_gen_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic             sel_vld,
  output logic             tout,
  output logic             err
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] last_grant, last_grant_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             vld_nxt;
  logic             tout_nxt;
  logic [SEL_W-1:0] winner;
  logic             any;
`ifdef SEL_GEN_XCHK_EN
  logic             err_nxt;
`endif

  rr_pick u_rr_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner_c   (winner),
    .any_c      (any)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    sel_nxt        = sel;
    vld_nxt        = sel_vld;
    tout_nxt       = 1'b0;
`ifdef SEL_GEN_XCHK_EN
    err_nxt        = 1'b0;
`endif
    case (state)
      IDLE: begin
        vld_nxt = 1'b0;
`ifdef SEL_GEN_XCHK_EN
        if ($isunknown(req)) err_nxt = 1'b1;
        else
`endif
        if (any) begin
          sel_nxt   = winner;
          vld_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A requested release takes precedence, so a coincident timeout stays silent.
        if (done || !req[sel]) begin
          vld_nxt        = 1'b0;
          last_grant_nxt = sel;
          state_nxt      = GAP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          vld_nxt        = 1'b0;
          tout_nxt       = 1'b1;
          last_grant_nxt = sel;
          state_nxt      = GAP;
        end
      end
      GAP: begin
        vld_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        vld_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= SEL_W'(N_REQ - 1);
      sel        <= '0;
      sel_vld    <= 1'b0;
      tout       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      sel        <= sel_nxt;
      sel_vld    <= vld_nxt;
      tout       <= tout_nxt;
    end
  end

`ifdef SEL_GEN_XCHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_nxt;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sel_gen.sv
// Directed vector bench for sel_gen with TIMEOUT=4.
module tb_sel_gen;

  localparam int unsigned TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] sel;
  logic       sel_vld;
  logic       tout;
  logic       err;

  sel_gen #(.TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .sel_vld (sel_vld),
    .tout    (tout),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic       vld;
    logic       tout;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [1:0] es, input logic ev, input logic et);
    n_chk++;
    if (sel !== es || sel_vld !== ev || tout !== et || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got sel=%0d vld=%b tout=%b err=%b, want sel=%0d vld=%b tout=%b err=0",
               name, sel, sel_vld, tout, err, es, ev, et);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic d, input logic [1:0] s,
                     input logic v, input logic t);
    vec_t x;
    x = '{req: r, done: d, sel: s, vld: v, tout: t};
    vecs.push_back(x);
  endtask

  initial begin
    // Idle with no requests.
    for (int i = 0; i < 5; i++) add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    // 1010 from reset: grant 1, done, gap, idle, then grant 3.
    add(4'b1010, 1'b0, 2'd1, 1'b1, 1'b0);
    add(4'b1010, 1'b1, 2'd1, 1'b0, 1'b0);
    add(4'b1010, 1'b0, 2'd1, 1'b0, 1'b0);
    add(4'b1010, 1'b0, 2'd3, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 2'd3, 1'b0, 1'b0);
    add(4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);
    // All requesting, done on third valid cycle: 0,1,2,3.
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 3; k++) add(4'b1111, 1'b0, 2'(g), 1'b1, 1'b0);
      add(4'b1111, 1'b1, 2'(g), 1'b0, 1'b0);
      add(4'b1111, 1'b0, 2'(g), 1'b0, 1'b0);
    end
    // Wrap to 0; done coincident with timeout gives no tout.
    for (int k = 0; k < 4; k++) add(4'b1111, 1'b0, 2'd0, 1'b1, 1'b0);
    add(4'b1111, 1'b1, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    // 0100 never done: 4 valid cycles, tout, gap, regrant 2.
    for (int k = 0; k < 4; k++) add(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
    add(4'b0100, 1'b0, 2'd2, 1'b0, 1'b1);
    add(4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
    add(4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
    // done in IDLE ignored, also alongside a new request.
    add(4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
    add(4'b0001, 1'b1, 2'd0, 1'b1, 1'b0);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    #12;
    check("reset", 2'd0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      req  = vecs[i].req;
      done = vecs[i].done;
      @(posedge clk) #1;
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].vld, vecs[i].tout);
    end

    // Reset in the middle of a grant to requester 3, then regrant after release.
    @(negedge clk);
    req  = 4'b1000;
    done = 1'b0;
    @(posedge clk) #1;
    check("rst_pre", 2'd3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("rst_async", 2'd0, 1'b0, 1'b0);
    @(posedge clk) #1;
    check("rst_hold", 2'd0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("rst_first", 2'd3, 1'b1, 1'b0);
    @(negedge clk) req = 4'b0000;
    @(posedge clk) #1;
    check("rst_rel", 2'd3, 1'b0, 1'b0);
    @(posedge clk) #1;
    check("rst_idle", 2'd3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sel_gen.md
SEL_GEN -- requirements
Module: sel_gen

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15, maximum grant duration in cycles before forced release (legal range 1..15).
REQ-002 SHALL provide port clk, input, 1, single clock; all state SHALL update on rising edge.
REQ-003 SHALL provide port rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL provide port req, input, 4, per-requester request, level-sensitive.
REQ-005 SHALL provide port done, input, 1, granted requester releases grant.
REQ-006 SHALL provide port sel, output, 2, registered binary code of granted requester (drives downstream 2-bit sel decoders).
REQ-007 SHALL provide port sel_vld, output, 1, registered; sel valid and stable while high.
REQ-008 SHALL provide port tout, output, 1, registered one-cycle pulse on forced release.
REQ-009 SHALL provide port err, output, 1, registered one-cycle pulse on X/Z request detection.

Function
REQ-010 SHALL implement FSM states IDLE, GRANT, GAP; unreachable encodings SHALL return to IDLE (explicit default item in every case statement).
REQ-011 IDLE: if req != 0, SHALL select winner round-robin starting at last_grant+1 mod 4, load sel, set sel_vld, clear hold counter, go GRANT; else stay IDLE, sel_vld=0.
REQ-012 Latency: req sampled at edge N SHALL give sel_vld=1 after edge N (one cycle).
REQ-013 GRANT: sel and sel_vld SHALL stay constant; hold counter SHALL increment each cycle.
REQ-014 GRANT: done=1 or req[sel]=0 SHALL release: sel_vld=0 after the edge, last_grant=sel, go GAP.
REQ-015 GRANT: counter reaching TIMEOUT without release SHALL force release as REQ-014 and pulse tout=1 for one cycle.
REQ-016 Simultaneous done and timeout SHALL be normal release; tout SHALL stay 0.
REQ-017 GAP SHALL last exactly one cycle with sel_vld=0, then IDLE; guarantees at least one invalid cycle between grants.
REQ-018 done in IDLE or GAP SHALL be ignored.
REQ-019 sel SHALL hold last value while sel_vld=0.
REQ-020 Round-robin wrap: last_grant=3 SHALL give priority order 0,1,2,3.

Reset
REQ-021 rst_n low SHALL immediately force IDLE, sel=2'b00, sel_vld=0, tout=0, err=0, counter=0, last_grant=3.
REQ-022 Reset asserted mid-GRANT SHALL drop sel_vld asynchronously; no tout pulse.
REQ-023 First grant after reset deassertion SHALL follow REQ-011/REQ-012 timing.

Configuration
REQ-024 Macro SEL_GEN_XCHK_EN defined: in IDLE, req containing X/Z SHALL pulse err for one cycle, issue no grant, remain IDLE.
REQ-025 Macro SEL_GEN_XCHK_EN undefined: err SHALL be tied 0; no X/Z checking logic compiled.

Structure
REQ-026 Package sel_gen_pkg SHALL hold state typedef (IDLE, GRANT, GAP), N_REQ=4, SEL_W=2, CNT_W=4.
REQ-027 Sub-module rr_pick SHALL be the combinational round-robin selector (inputs req, last_grant; outputs winner code, any).
REQ-028 Total RTL 120-400 lines.

Verification
REQ-029 Reset, req=4'b0000 for 5 cycles -> sel_vld=0, sel=00, tout=0, err=0 throughout.
REQ-030 req=4'b1010 from reset -> sel=01, sel_vld=1 one cycle later; done pulse -> sel_vld=0, GAP, next grant sel=11.
REQ-031 req=4'b1111 held, done every 3rd grant cycle -> grant sequence 00,01,10,11,00 with one idle cycle between each.
REQ-032 TIMEOUT=4, req=4'b0100, done never -> sel=10 valid 4 cycles, tout pulse with release, regrant sel=10 after GAP.
REQ-033 rst_n low during GRANT sel=11 -> sel_vld=0 immediately; after release req=4'b1000 -> sel=11 granted, no tout.
REQ-034 SEL_GEN_XCHK_EN defined, req=4'b1x00 in IDLE -> err=1 one cycle, sel_vld stays 0; undefined build -> err=0.
